// File: rtl/apb_master.sv
// Single-outstanding APB initiator: converts a command handshake into APB
// SETUP/ACCESS transfers and returns a one-cycle response (read data or timeout).
module apb_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,
    output logic              apb_sel,
    output logic              apb_enable,
    output logic              apb_write,
    output logic [ADDR_W-1:0] apb_addr,
    output logic [DATA_W-1:0] apb_wdata,
    input  logic [DATA_W-1:0] apb_rdata,
    input  logic              apb_ready
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t            r_state,       w_state_nxt;
    logic [CNT_W-1:0]  r_wait_cnt,    w_wait_cnt_nxt;
    logic              r_cmd_ready,   w_cmd_ready_nxt;
    logic              r_rsp_valid,   w_rsp_valid_nxt;
    logic              r_rsp_timeout, w_rsp_timeout_nxt;
    logic [DATA_W-1:0] r_rsp_rdata,   w_rsp_rdata_nxt;
    logic              r_sel,         w_sel_nxt;
    logic              r_enable,      w_enable_nxt;
    logic              r_write,       w_write_nxt;
    logic [ADDR_W-1:0] r_addr,        w_addr_nxt;
    logic [DATA_W-1:0] r_wdata,       w_wdata_nxt;

    // State and registered-output flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_wait_cnt    <= '0;
            r_cmd_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_rdata   <= '0;
            r_sel         <= 1'b0;
            r_enable      <= 1'b0;
            r_write       <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
            r_cmd_ready   <= w_cmd_ready_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_sel         <= w_sel_nxt;
            r_enable      <= w_enable_nxt;
            r_write       <= w_write_nxt;
            r_addr        <= w_addr_nxt;
            r_wdata       <= w_wdata_nxt;
        end
    end

    // Next-state and next-output logic; response flags are single-cycle pulses.
    always_comb begin
        w_state_nxt       = r_state;
        w_wait_cnt_nxt    = r_wait_cnt;
        w_cmd_ready_nxt   = r_cmd_ready;
        w_rsp_valid_nxt   = 1'b0;
        w_rsp_timeout_nxt = 1'b0;
        w_rsp_rdata_nxt   = r_rsp_rdata;
        w_sel_nxt         = r_sel;
        w_enable_nxt      = r_enable;
        w_write_nxt       = r_write;
        w_addr_nxt        = r_addr;
        w_wdata_nxt       = r_wdata;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_state_nxt     = S_SETUP;
                    w_wait_cnt_nxt  = '0;
                    w_cmd_ready_nxt = 1'b0;
                    w_sel_nxt       = 1'b1;
                    w_enable_nxt    = 1'b0;
                    w_write_nxt     = cmd_write;
                    w_addr_nxt      = cmd_addr;
                    w_wdata_nxt     = cmd_wdata;
                end else begin
                    w_cmd_ready_nxt = 1'b1;
                end
            end
            S_SETUP: begin
                w_state_nxt  = S_ACCESS;
                w_sel_nxt    = 1'b1;
                w_enable_nxt = 1'b1;
            end
            S_ACCESS: begin
                // Slave ready takes priority over a timeout on the same edge.
                if (apb_ready) begin
                    if (!r_write) begin
                        w_rsp_rdata_nxt = apb_rdata;
                    end else begin
                        w_rsp_rdata_nxt = r_rsp_rdata;
                    end
                    w_state_nxt     = S_IDLE;
                    w_rsp_valid_nxt = 1'b1;
                    w_cmd_ready_nxt = 1'b1;
                    w_sel_nxt       = 1'b0;
                    w_enable_nxt    = 1'b0;
                end else if (r_wait_cnt == CNT_MAX) begin
                    w_state_nxt       = S_IDLE;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_timeout_nxt = 1'b1;
                    w_cmd_ready_nxt   = 1'b1;
                    w_sel_nxt         = 1'b0;
                    w_enable_nxt      = 1'b0;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_cmd_ready_nxt = 1'b1;
                w_sel_nxt       = 1'b0;
                w_enable_nxt    = 1'b0;
            end
        endcase
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_timeout = r_rsp_timeout;
    assign rsp_rdata   = r_rsp_rdata;
    assign apb_sel     = r_sel;
    assign apb_enable  = r_enable;
    assign apb_write   = r_write;
    assign apb_addr    = r_addr;
    assign apb_wdata   = r_wdata;

endmodule
